// File: rtl/float_point_div.sv
// float_point_div: sequential binary32 divider, out = A / B.
// Restoring radix-2 mantissa division, one quotient bit per clock, with a
// start/done handshake. Arithmetic is truncating, produces no NaN, and treats
// subnormal operands (exponent 0) as zero. Latency is fixed at 26 clocks from
// acceptance to done, whatever the operand values.
module float_point_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        dz,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

  // Last CALC step: the counter runs 0..24, giving 25 quotient bits.
  localparam logic [4:0] LAST_STEP = 5'd24;

  state_t      state;
  logic [4:0]  step_cnt;
  logic [25:0] rem;       // partial remainder, two headroom bits over the mantissa
  logic [23:0] dvsr;      // divisor mantissa with hidden bit
  logic [24:0] quo;       // quotient, quo[24] is the integer bit
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic        sign;
  logic        a_zero;
  logic        b_zero;

  // One restoring step: trial subtract, keep or restore, then shift left.
  logic        qbit;
  logic [25:0] rem_sel;
  logic [25:0] rem_next;

  // Normalisation and result selection, consumed in NORM.
  logic signed [9:0] exp_calc;
  logic [22:0]       mant;
  logic [31:0]       res_out;
  logic              res_dz;
  logic              res_ovf;
  logic              res_unf;

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    qbit     = 1'b0;
    rem_sel  = rem;
    rem_next = '0;
    if (rem >= {2'b00, dvsr}) begin
      qbit    = 1'b1;
      rem_sel = rem - {2'b00, dvsr};
    end
    rem_next = {rem_sel[24:0], 1'b0};
  end

  // Normalise the quotient and apply the special-case priority.
  always_comb begin
    res_out = '0;
    res_dz  = 1'b0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    // Ma/Mb lies in (0.5, 2): either the integer bit or the first fraction
    // bit is set, so one position of shift is all normalisation needs.
    if (quo[24]) begin
      mant     = quo[23:1];
      exp_calc = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
    end else begin
      mant     = quo[22:0];
      exp_calc = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd126;
    end

    if (b_zero) begin
      // Divide by zero, including 0/0: defined as signed infinity.
      res_out = {sign, 8'hFF, 23'h0};
      res_dz  = 1'b1;
    end else if (a_zero) begin
      res_out = 32'h0;
    end else if (exp_calc >= 10'sd255) begin
      res_out = {sign, 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else if (exp_calc <= 10'sd0) begin
      res_out = 32'h0;
      res_unf = 1'b1;
    end else begin
      res_out = {sign, exp_calc[7:0], mant};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
      rem      <= '0;
      dvsr     <= '0;
      quo      <= '0;
      exp_a    <= '0;
      exp_b    <= '0;
      sign     <= 1'b0;
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values and evaluation order inside the block is irrelevant.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign     <= A[31] ^ B[31];
            exp_a    <= A[30:23];
            exp_b    <= B[30:23];
            a_zero   <= (A[30:23] == 8'h00);
            b_zero   <= (B[30:23] == 8'h00);
            rem      <= {2'b00, 1'b1, A[22:0]};
            dvsr     <= {1'b1, B[22:0]};
            quo      <= '0;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          // Zero operands run the full sequence too, keeping latency fixed.
          rem      <= rem_next;
          quo      <= {quo[23:0], qbit};
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == LAST_STEP) begin
            state <= NORM;
          end
        end
        NORM: begin
          out   <= res_out;
          dz    <= res_dz;
          ovf   <= res_ovf;
          unf   <= res_unf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_point_div.sv
// tb_float_point_div: directed vectors for float_point_div. Stimulus pushes
// the hand-computed expected result into a scoreboard; an independent
// monitor pops and compares whenever done is seen.
module tb_float_point_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        dz;
  logic        ovf;
  logic        unf;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        dz;
    logic        ovf;
    logic        unf;
    int          acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  float_point_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .dz    (dz),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_out"}, 64'(out), 64'(e.out));
        check({e.name, "_flags"}, 64'({dz, ovf, unf}), 64'({e.dz, e.ovf, e.unf}));
        check({e.name, "_latency"}, 64'(cycle - e.acc_cycle), 64'd26);
      end
    end
  end

  // Wait (bounded) until the divider is idle, at a negedge.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Present operands at a negedge; acceptance is the following posedge.
  // Returns at the negedge after the accepting edge with start dropped.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic edz, input logic eovf,
                       input logic eunf);
    exp_t e;
    wait_idle();
    A     = a;
    B     = b;
    start = 1'b1;
    e.name = name; e.out = eo; e.dz = edz; e.ovf = eovf; e.unf = eunf;
    e.acc_cycle = cycle + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = 32'hDEAD_BEEF;
    B     = 32'h1234_5678;
  endtask

  // Wait (bounded) for done, counting negedges that see busy high.
  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (busy) busy_n++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eo, input logic edz, input logic eovf,
                     input logic eunf);
    int bn;
    issue(name, a, b, eo, edz, eovf, eunf);
    wait_done(bn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_flags", 64'({dz, ovf, unf}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide with busy-length and done-width checks.
    issue("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    wait_done(bn);
    check("busy_cycles", 64'(bn), 64'd26);
    check("busy_low_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
    check("out_held", 64'(out), 64'h40400000);

    run("trunc_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0);
    run("sign_neg",  32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 1'b0, 1'b0);
    run("div_zero",  32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    run("zero_num",  32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    run("zero_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    run("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    run("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run("flag_clear", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);

    // start pulsed at edge 10 with other operands must be ignored.
    issue("ignore_start", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    A     = 32'h7F000000;
    B     = 32'h3E800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn);
    repeat (3) @(negedge clk);
    check("no_extra_op", 64'(sb.size()), 64'd0);

    // Reset at edge 12 of an operation aborts it immediately.
    issue("aborted", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out", 64'(out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("no_stray_done", 64'(done), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
